// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multicycle main control FSM
package cpu_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] MEMREAD  = 4'd3;
  localparam logic [STATE_W-1:0] MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] MEMWRITE = 4'd5;
  localparam logic [STATE_W-1:0] EXECUTE  = 4'd6;
  localparam logic [STATE_W-1:0] ALUWB    = 4'd7;
  localparam logic [STATE_W-1:0] BRANCH   = 4'd8;
  localparam logic [STATE_W-1:0] JUMP     = 4'd9;

  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;
  localparam logic [5:0] OP_BEQ       = 6'b010000;
  localparam logic [5:0] OP_J         = 6'b010001;
  localparam logic [2:0] OP_RTYPE_PFX = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    OPC_RTYPE,
    OPC_LW,
    OPC_SW,
    OPC_BEQ,
    OPC_J,
    OPC_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [5:0] op);
    if (op[5:3] == OP_RTYPE_PFX) return OPC_RTYPE;
    else if (op == OP_LW)        return OPC_LW;
    else if (op == OP_SW)        return OPC_SW;
    else if (op == OP_BEQ)       return OPC_BEQ;
    else if (op == OP_J)         return OPC_J;
    else                         return OPC_ILLEGAL;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - registered state to datapath control word
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_B;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    // Reset forces a quiet control word so no in-flight write can leak out.
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = ALUSRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = ALUSRCB_IMMSH;
          illegal_op = (classify(opcode) == OPC_ILLEGAL);
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUSRCB_IMM;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle CPU main control state machine
module multicycle_main_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int SW_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUOp,
  output logic           instr_done,
  output logic           illegal_op
);

  logic [SW_W-1:0] state;
  logic [SW_W-1:0] next_state;

  // The branch decision is taken in the datapath through PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (classify(opcode))
          OPC_RTYPE: next_state = EXECUTE;
          OPC_LW,
          OPC_SW:    next_state = MEMADR;
          OPC_BEQ:   next_state = BRANCH;
          OPC_J:     next_state = JUMP;
          default:   next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (classify(opcode) == OPC_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  ctrl_output_decode u_decode (
    .reset       (reset),
    .state       (state),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed bench for the main control FSM
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // Field order: PCW PCWC IorD MR MW IRW M2R RD RW ASA ASB[2] PCS[2] AOP[2] done ill
  logic [17:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op};

  localparam logic [17:0] E_ZERO     = 18'b0;
  localparam logic [17:0] E_FETCH_R  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_FETCH_W  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
  localparam logic [17:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MEMREAD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MEMWR_W  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MEMWR_R  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_EXECUTE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0,1'b0};
  localparam logic [17:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_BRANCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b1,1'b0};

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctl !== E_ZERO) $display("FAIL reset_hold cyc%0d: got %h expected %h", i, ctl, E_ZERO);
      else passed++;
      next_cycle();
    end
    reset = 1'b0;
    #1;
    total++;
    if (ctl !== E_FETCH_R) $display("FAIL reset_release: got %h expected %h", ctl, E_FETCH_R);
    else passed++;
  endtask

  task automatic test_rtype();
    logic [17:0] e[5];
    logic        r[5];
    e = '{E_FETCH_W, E_FETCH_R, E_DECODE, E_EXECUTE, E_ALUWB};
    r = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    opcode = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL rtype cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    logic [17:0] e[7];
    logic        r[7];
    e = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL lw_wait cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_sw();
    logic [17:0] e[4];
    opcode = 6'b101011;
    mem_ready = 1'b1;
    e = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_R};
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL sw cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_beq();
    logic [17:0] e[4];
    logic        r[4];
    e = '{E_FETCH_R, E_DECODE, E_BRANCH, E_FETCH_W};
    r = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 6'b010000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL beq cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e[7];
    logic [5:0]  o[7];
    o = '{6'b010001, 6'b010001, 6'b010001, 6'b000111, 6'b000111, 6'b000111, 6'b000111};
    e = '{E_FETCH_R, E_DECODE, E_JUMP, E_FETCH_R, E_DECODE, E_EXECUTE, E_ALUWB};
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = o[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL back_to_back cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic [17:0] e[6];
    logic [5:0]  o[6];
    logic        r[6];
    o = '{6'b111111, 6'b111111, 6'b111111, 6'b100000, 6'b100000, 6'b100000};
    e = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W, E_FETCH_R, E_DEC_ILL, E_FETCH_W};
    r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      opcode = o[i];
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL illegal cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [17:0] e[5];
    logic        r[5];
    e = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_W};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) $display("FAIL reset_mid cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passed++;
      if (i < 4) next_cycle();
    end
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== E_ZERO) $display("FAIL reset_mid_during: got %h expected %h", ctl, E_ZERO);
    else passed++;
    next_cycle();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== E_FETCH_W) $display("FAIL reset_mid_after: got %h expected %h", ctl, E_FETCH_W);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_sw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM of the multicycle CPU, directly upstream of the ALU control decoder.
- Sequences every instruction through fetch, decode, execute, memory and writeback cycles.
- Drives all datapath enables and the 2-bit ALUOp that the ALU control decoder consumes; the decoder forms ALUSelect from ALUOp and opcode[2:0].
- Inserts wait states on instruction and data memory accesses via a ready handshake.

Parameters:
- OPW, 6, opcode width (fixed by the ISA; do not override).
- SW_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPW  IR[31:26]; stable from the cycle after FETCH completes.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero.
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = A.
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  00 = add, 01 = sub, 10 = function from opcode[2:0].
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal_op  output  1  one-cycle pulse in DECODE for an unknown opcode.

Behaviour:
- Opcode map:
  - 6'b000xxx R-type ALU operation.
  - 6'b100011 LW.
  - 6'b101011 SW.
  - 6'b010000 BEQ.
  - 6'b010001 J.
  - All other encodings are illegal.
- Reset: state <= FETCH. While reset is high, all outputs are 0.
- Outputs are Moore-decoded from the registered state. The exceptions are IRWrite and PCWrite in FETCH, which are additionally gated by mem_ready. Every output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Transition: DECODE if mem_ready, else stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Transition: R-type -> EXECUTE; LW/SW -> MEMADR; BEQ -> BRANCH; J -> JUMP; illegal -> FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMREAD for LW, MEMWRITE for SW.
- MEMREAD:
  - Outputs: MemRead=1, IorD=1.
  - Transition: stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next: FETCH.
- MEMWRITE:
  - Outputs: MemWrite=1, IorD=1.
  - Transition: stay until mem_ready, then FETCH with instr_done=1 in that last cycle.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next: FETCH.
- Latency with mem_ready=1 throughout: R-type 4, LW 5, SW 4, BEQ 3, J 3 cycles. Each wait cycle adds 1.
- MemRead and MemWrite are never both 1.
- ALUOp is never 11.
- Unused state encodings decode as FETCH on the next edge.
- Reset mid-instruction: the next cycle is FETCH with all outputs 0 during reset. No partial RegWrite or MemWrite occurs after reset.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings (FETCH=0 ... JUMP=9);
  - opcode constants OP_LW, OP_SW, OP_BEQ, OP_J and the R-type class prefix 3'b000;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - ALUSrcB and PCSource constants.
- One natural sub-module: ctrl_output_decode, a combinational state -> control-word decoder. The FSM keeps only the state register and next-state logic.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> all outputs 0 during reset; first post-reset cycle has MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- opcode=6'b000010 with mem_ready=1 -> states FETCH, DECODE, EXECUTE (ALUOp=10), ALUWB (RegWrite=1, RegDst=1) -> instr_done on cycle 4.
- LW 6'b100011, mem_ready low for 2 cycles in MEMREAD -> MemRead and IorD held 3 cycles, then MEMWB with RegWrite=1, MemtoReg=1; total 7 cycles.
- BEQ 6'b010000 -> BRANCH cycle shows ALUOp=01, PCWriteCond=1, PCSource=01; back in FETCH on cycle 4.
- opcode=6'b111111 -> illegal_op pulses in DECODE, next state FETCH, no RegWrite or MemWrite asserted.
- SW in MEMWRITE with mem_ready=0, reset asserted -> MemWrite drops to 0 during reset; state is FETCH after release.
